// File: rtl/op_sequencer.sv
// Start/finished initiator: runs NUM_CHILDREN child FSMs in index order for a
// latched number of passes. It also answers the same start/finished protocol
// upstream, so sequencers can nest.
module op_sequencer #(
  parameter int unsigned NUM_CHILDREN   = 4,
  parameter int unsigned IDX_WIDTH      = 2,
  parameter int unsigned ITER_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start_i,
  input  logic [ITER_WIDTH-1:0]   iterations_i,
  output logic                    finished_o,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_finished_i,
  output logic [IDX_WIDTH-1:0]    cur_child_o,
  output logic [ITER_WIDTH-1:0]   iter_done_o,
  output logic                    error_o
);

  typedef enum logic [2:0] {
    StStandby,
    StCheck,
    StLoadStart,
    StLoadDelay,
    StLoadWait,
    StAdvance
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cur_child_q, cur_child_d;
  logic [ITER_WIDTH-1:0] iter_done_q, iter_done_d;
  logic [ITER_WIDTH-1:0] iter_left_q, iter_left_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  error_q, error_d;

  logic                  sel_finished;
  logic                  last_child;
  logic [16:0]           tmo_next;
  logic                  tmo_hit;

  assign sel_finished = child_finished_i[cur_child_q];
  assign last_child   = (cur_child_q == IDX_WIDTH'(NUM_CHILDREN - 1));
  assign tmo_next     = {1'b0, tmo_cnt_q} + 17'd1;
  // Fires on the LOAD_WAIT cycle that would bring the count to TIMEOUT_CYCLES.
  assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (32'(tmo_next) >= TIMEOUT_CYCLES);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StStandby;
      cur_child_q <= '0;
      iter_done_q <= '0;
      iter_left_q <= '0;
      tmo_cnt_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_child_q <= cur_child_d;
      iter_done_q <= iter_done_d;
      iter_left_q <= iter_left_d;
      tmo_cnt_q   <= tmo_cnt_d;
      error_q     <= error_d;
    end
  end

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    cur_child_d = cur_child_q;
    iter_done_d = iter_done_q;
    iter_left_d = iter_left_q;
    tmo_cnt_d   = tmo_cnt_q;
    error_d     = error_q;

    unique case (state_q)
      StStandby: begin
        if (start_i) begin
          iter_left_d = iterations_i;
          cur_child_d = '0;
          iter_done_d = '0;
          error_d     = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (iter_left_q == '0) begin
          state_d = StStandby;
        end else begin
          tmo_cnt_d = '0;
          state_d   = StLoadStart;
        end
      end
      StLoadStart: begin
        state_d = StLoadDelay;
      end
      StLoadDelay: begin
        state_d = StLoadWait;
      end
      StLoadWait: begin
        if (sel_finished) begin
          state_d = StAdvance;
        end else if (tmo_hit) begin
          // cur_child and iter_done are left as-is to show where it stalled.
          error_d = 1'b1;
          state_d = StStandby;
        end else begin
          tmo_cnt_d = tmo_next[15:0];
        end
      end
      StAdvance: begin
        if (last_child) begin
          cur_child_d = '0;
          iter_done_d = iter_done_q + ITER_WIDTH'(1);
          iter_left_d = iter_left_q - ITER_WIDTH'(1);
        end else begin
          cur_child_d = cur_child_q + IDX_WIDTH'(1);
        end
        state_d = StCheck;
      end
      default: begin
        state_d = StStandby;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    child_start_o = '0;
    if (state_q == StLoadStart || state_q == StLoadDelay) begin
      child_start_o[cur_child_q] = 1'b1;
    end
  end

  assign finished_o  = (state_q == StStandby);
  assign cur_child_o = cur_child_q;
  assign iter_done_o = iter_done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: a run-level reference model pushes the
// expected child start order and completion summary; a negedge monitor pops
// and compares whenever the DUT starts a child or raises finished.
module tb_op_sequencer;
  localparam int NC  = 3;
  localparam int IW  = 2;
  localparam int ITW = 8;
  localparam int TMO = 10;

  logic           clock = 1'b0;
  logic           resetn;
  logic           start;
  logic [ITW-1:0] iterations;
  logic           finished;
  logic [NC-1:0]  child_start;
  logic [NC-1:0]  child_finished;
  logic [IW-1:0]  cur_child;
  logic [ITW-1:0] iter_done;
  logic           error;

  always #5 clock = ~clock;

  op_sequencer #(
    .NUM_CHILDREN  (NC),
    .IDX_WIDTH     (IW),
    .ITER_WIDTH    (ITW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start_i         (start),
    .iterations_i    (iterations),
    .finished_o      (finished),
    .child_start_o   (child_start),
    .child_finished_i(child_finished),
    .cur_child_o     (cur_child),
    .iter_done_o     (iter_done),
    .error_o         (error)
  );

  // Child models: drop finished on start, finish work[i] cycles after start ends.
  logic [NC-1:0] fin_q;
  int            cnt_q [NC];
  int            work  [NC];
  logic [NC-1:0] hang = '0;
  bit            imm = 1'b0;

  always @(posedge clock) begin
    for (int i = 0; i < NC; i++) begin
      if (!resetn) begin
        fin_q[i] <= 1'b1;
      end else if (child_start[i]) begin
        fin_q[i] <= 1'b0;
        cnt_q[i] <= work[i];
      end else if (!fin_q[i] && !hang[i]) begin
        if (cnt_q[i] <= 1) fin_q[i] <= 1'b1;
        else cnt_q[i] <= cnt_q[i] - 1;
      end
    end
  end

  assign child_finished = imm ? '1 : fin_q;

  typedef struct {
    int iters;
    int err;
    int cur;
    int cycles;
  } done_t;

  int    exp_starts[$];
  done_t exp_done[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compares child start pulses and run completions against the queues.
  initial begin
    logic [NC-1:0] prev_cs;
    bit            prev_fin;
    int            cs_w;
    int            low_cnt;
    int            e;
    done_t         d;
    prev_cs  = '0;
    prev_fin = 1'b1;
    cs_w     = 0;
    low_cnt  = 0;
    forever begin
      @(negedge clock);
      if (child_start != '0) begin
        if (prev_cs == '0) begin
          cs_w = 1;
          if (mon_en) begin
            check("start_onehot", $countones(child_start), 1);
            if (exp_starts.size() == 0) begin
              check("unexpected_start", 32'(child_start), 0);
            end else begin
              e = exp_starts.pop_front();
              check("start_child", 32'(child_start), 1 << (e / 256));
              check("start_iter", 32'(iter_done), e % 256);
            end
          end
        end else begin
          cs_w++;
        end
      end else if (prev_cs != '0 && mon_en) begin
        check("start_width", cs_w, 2);
      end
      if (finished === 1'b0) low_cnt++;
      if (finished === 1'b1 && !prev_fin) begin
        if (mon_en) begin
          if (exp_done.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            d = exp_done.pop_front();
            check("done_iter_done", 32'(iter_done), d.iters);
            check("done_error", 32'(error), d.err);
            check("done_cur_child", 32'(cur_child), d.cur);
            check("done_busy_cycles", low_cnt, d.cycles);
          end
        end
        low_cnt = 0;
      end
      prev_cs  = child_start;
      prev_fin = (finished === 1'b1);
    end
  end

  // Reference model for one run, then drive it and wait for completion.
  task automatic run(input int n, input bit poke, input int hang_idx);
    int    cyc;
    int    kc [NC];
    bit    done;
    bit    poked;
    bit    prev_cs;
    done_t d;
    cyc = 0;
    for (int c = 0; c < NC; c++) kc[c] = imm ? 1 : work[c] + 1;
    if (hang_idx < 0) begin
      for (int it = 0; it < n; it++) begin
        for (int c = 0; c < NC; c++) begin
          exp_starts.push_back(c * 256 + (it % 256));
          cyc += 4 + kc[c];
        end
      end
      d.iters  = n % 256;
      d.err    = 0;
      d.cur    = 0;
      d.cycles = cyc + 1;
    end else begin
      for (int c = 0; c <= hang_idx; c++) exp_starts.push_back(c * 256);
      for (int c = 0; c < hang_idx; c++) cyc += 4 + kc[c];
      d.iters  = 0;
      d.err    = 1;
      d.cur    = hang_idx;
      d.cycles = cyc + 3 + TMO;
      hang[hang_idx] = 1'b1;
    end
    exp_done.push_back(d);

    @(posedge clock);
    #1;
    start      = 1'b1;
    iterations = ITW'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    check("accept_finished_low", 32'(finished), 0);
    check("accept_error_clr", 32'(error), 0);
    check("accept_iter_done_clr", 32'(iter_done), 0);
    check("accept_cur_child_clr", 32'(cur_child), 0);

    done    = 1'b0;
    poked   = 1'b0;
    prev_cs = 1'b0;
    for (int g = 0; g < 3000 && !done; g++) begin
      if (finished === 1'b1) begin
        done = 1'b1;
      end else begin
        if (start) start = 1'b0;
        // First LOAD_WAIT cycle: start pulse with a different count must be ignored.
        if (poke && !poked && prev_cs && child_start == '0) begin
          start      = 1'b1;
          iterations = 8'd5;
          poked      = 1'b1;
        end
        prev_cs = |child_start;
        @(negedge clock);
      end
    end
    start = 1'b0;
    hang  = '0;
    if (!done) begin
      check("run_completes_in_bound", 0, 1);
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      exp_starts.delete();
      exp_done.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  initial begin
    bit found;
    int n;
    int h;
    resetn     = 1'b0;
    start      = 1'b0;
    iterations = '0;
    for (int i = 0; i < NC; i++) work[i] = 2;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    check("reset_finished", 32'(finished), 1);
    check("reset_child_start", 32'(child_start), 0);
    check("reset_cur_child", 32'(cur_child), 0);
    check("reset_iter_done", 32'(iter_done), 0);
    check("reset_error", 32'(error), 0);

    // Reset while in LOAD_DELAY for child 1.
    @(posedge clock);
    #1;
    start      = 1'b1;
    iterations = 8'd1;
    @(posedge clock);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 200 && !found; g++) begin
      @(negedge clock);
      if (child_start[1]) found = 1'b1;
    end
    check("midrst_reach_child1", 32'(found), 1);
    @(negedge clock);
    check("midrst_in_delay", 32'(child_start), 2);
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_child_start", 32'(child_start), 0);
    check("midrst_finished", 32'(finished), 1);
    check("midrst_cur_child", 32'(cur_child), 0);
    check("midrst_iter_done", 32'(iter_done), 0);
    check("midrst_error", 32'(error), 0);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    mon_en = 1'b1;

    // Normal run: two passes, 4-cycle child work.
    for (int i = 0; i < NC; i++) work[i] = 4;
    run(2, 1'b0, -1);
    // Zero iterations.
    run(0, 1'b0, -1);
    // Start while busy is ignored.
    run(2, 1'b1, -1);
    // Children already finished: k=1 each.
    imm = 1'b1;
    run(1, 1'b0, -1);
    imm = 1'b0;
    // Child 1 never finishes, then a clean run clears error.
    run(1, 1'b0, 1);
    run(1, 1'b0, -1);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NC; i++) work[i] = $urandom_range(1, 6);
      imm = ($urandom_range(0, 3) == 0);
      n   = $urandom_range(0, 4);
      h   = -1;
      if (!imm && n > 0 && $urandom_range(0, 4) == 0) h = $urandom_range(0, NC - 1);
      run(n, $urandom_range(0, 1) == 1, h);
    end
    imm = 1'b0;

    repeat (4) @(posedge clock);
    check("leftover_starts", exp_starts.size(), 0);
    check("leftover_dones", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
